// File: rtl/multi_seq_n.sv
// multi_seq_n: iterative N x N signed/unsigned multiplier with HI/LO result and start/done handshake.
// Optional MULT_ACC_EN adds acc_i: the completion adds the product into {hi_o,lo_o} (MADD/MADDU).
module multi_seq_n #(
    parameter int N              = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic         signed_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
`ifdef MULT_ACC_EN
    input  logic         acc_i,
`endif
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] hi_o,
    output logic [N-1:0] lo_o
);

    localparam int K  = N / BITS_PER_CYCLE;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    generate
        if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4) ||
            (N % BITS_PER_CYCLE) != 0) begin : g_bad_param
            $error("multi_seq_n: BITS_PER_CYCLE must be 1, 2 or 4 and divide N");
        end
    endgenerate

    // CMPL is a separate busy cycle so the result lands K+2 edges after start
    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        CMPL
    } state_t;

    state_t          state, state_nxt;
    logic [2*N-1:0]  mcand;
    logic [2*N-1:0]  acc;
    logic [2*N-1:0]  partial;
    logic [N-1:0]    mplier;
    logic [N-1:0]    a_mag, b_mag;
    logic            neg;
    logic [CW-1:0]   cnt;
`ifdef MULT_ACC_EN
    logic            acc_mode;
`endif

    always_comb begin
        state_nxt = state;
        busy_o    = (state != IDLE);
        case (state)
            IDLE: if (start_i) state_nxt = CALC;
            CALC: if (cnt == CW'(K - 1)) state_nxt = FIX;
            FIX:  state_nxt = CMPL;
            CMPL: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        a_mag = (signed_i && a_i[N-1]) ? -a_i : a_i;
        b_mag = (signed_i && b_i[N-1]) ? -b_i : b_i;
    end

    // multiplicand is pre-shifted, so each retired multiplier bit adds a shifted copy
    always_comb begin
        partial = '0;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier[i]) partial = partial + (mcand << i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            neg      <= 1'b0;
            cnt      <= '0;
            done_o   <= 1'b0;
            hi_o     <= '0;
            lo_o     <= '0;
`ifdef MULT_ACC_EN
            acc_mode <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        mcand    <= {{N{1'b0}}, a_mag};
                        mplier   <= b_mag;
                        neg      <= signed_i & (a_i[N-1] ^ b_i[N-1]);
                        acc      <= '0;
                        cnt      <= '0;
`ifdef MULT_ACC_EN
                        acc_mode <= acc_i;
`endif
                    end
                end
                CALC: begin
                    acc    <= acc + partial;
                    mcand  <= mcand << BITS_PER_CYCLE;
                    mplier <= mplier >> BITS_PER_CYCLE;
                    cnt    <= cnt + CW'(1);
                end
                FIX: begin
                    if (neg) acc <= -acc;
                end
                CMPL: begin
`ifdef MULT_ACC_EN
                    if (acc_mode) {hi_o, lo_o} <= {hi_o, lo_o} + acc;
                    else          {hi_o, lo_o} <= acc;
`else
                    {hi_o, lo_o} <= acc;
`endif
                    done_o <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_seq_n.sv
// Directed bench for multi_seq_n: vector table plus back-to-back, abort and accumulate sequences.
module tb_multi_seq_n;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start4 = 1'b0;
    logic        sgn = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, busy4, done4;
    logic [31:0] hi, lo, hi4, lo4;
`ifdef MULT_ACC_EN
    logic        acc = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multi_seq_n #(.N(32), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .signed_i(sgn),
        .a_i(a), .b_i(b),
`ifdef MULT_ACC_EN
        .acc_i(acc),
`endif
        .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
    );

    multi_seq_n #(.N(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start_i(start4), .signed_i(sgn),
        .a_i(a), .b_i(b),
`ifdef MULT_ACC_EN
        .acc_i(acc),
`endif
        .busy_o(busy4), .done_o(done4), .hi_o(hi4), .lo_o(lo4)
    );

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic launch(input bit sel, input logic s, input logic [31:0] ia, input logic [31:0] ib);
        @(negedge clk);
        sgn = s; a = ia; b = ib;
        if (sel) start4 = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start4 = 1'b0;
    endtask

    task automatic wait_done(input bit sel, output int lat, output bit busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        while (((sel ? done4 : done) !== 1'b1) && lat < 100) begin
            if ((sel ? busy4 : busy) !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_op(input bit sel, input logic s, input logic [31:0] ia, input logic [31:0] ib,
                         input int exp_lat, input logic [31:0] ehi, input logic [31:0] elo,
                         input string nm);
        int lat;
        bit bok;
        launch(sel, s, ia, ib);
        wait_done(sel, lat, bok);
        chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({nm, "_busy_during"}, 64'(bok), 64'd1);
        chk({nm, "_product"}, sel ? {hi4, lo4} : {hi, lo}, {ehi, elo});
        chk({nm, "_busy_at_done"}, 64'(sel ? busy4 : busy), 64'd0);
        @(posedge clk); #1;
        chk({nm, "_done_pulse"}, 64'(sel ? done4 : done), 64'd0);
    endtask

    initial begin
        int  lat;
        bit  bok;
        bit  seen;

        vecs[0]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{1'b1, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[2]  = '{1'b1, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 32'h80000000};
        vecs[3]  = '{1'b0, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F};
        vecs[4]  = '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[5]  = '{1'b0, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000};
        vecs[6]  = '{1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[7]  = '{1'b1, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006};
        vecs[8]  = '{1'b0, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
        vecs[9]  = '{1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
        vecs[10] = '{1'b1, 32'h00000005, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF1};

        // reset state
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_hilo4", {hi4, lo4}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            do_op(1'b0, vecs[i].s, vecs[i].a, vecs[i].b, 34, vecs[i].hi, vecs[i].lo,
                  $sformatf("vec%0d", i));
        end

        // four bits per cycle: K=8, latency 10
        do_op(1'b1, 1'b0, 32'hDEADBEEF, 32'h00000010, 10, 32'h0000000D, 32'hEADBEEF0, "bpc4_u");
        do_op(1'b1, 1'b1, 32'hFFFFFFFF, 32'h00000001, 10, 32'hFFFFFFFF, 32'hFFFFFFFF, "bpc4_s");

        // start while busy is ignored; start in the done cycle is accepted
        launch(1'b0, 1'b0, 32'd3, 32'd5);
        repeat (9) @(posedge clk);
        @(negedge clk);
        a = 32'd7; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1'b0, lat, bok);
        chk("b2b_first_latency", 64'(lat), 64'd24);
        chk("b2b_first_product", {hi, lo}, 64'h0000000F);
        launch(1'b0, 1'b0, 32'd7, 32'd7);
        chk("b2b_busy_after_restart", 64'(busy), 64'd1);
        wait_done(1'b0, lat, bok);
        chk("b2b_second_latency", 64'(lat), 64'd34);
        chk("b2b_second_product", {hi, lo}, 64'h00000031);

        // asynchronous abort mid-operation
        launch(1'b0, 1'b0, 32'h1234, 32'h10);
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        chk("abort_hilo4", {hi4, lo4}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        chk("abort_no_done", 64'(seen), 64'd0);
        do_op(1'b0, 1'b0, 32'd2, 32'd3, 34, 32'd0, 32'd6, "after_abort");

`ifdef MULT_ACC_EN
        acc = 1'b0;
        do_op(1'b0, 1'b0, 32'd1, 32'd5, 34, 32'd0, 32'h5, "acc_load");
        acc = 1'b1;
        do_op(1'b0, 1'b0, 32'd3, 32'd4, 34, 32'd0, 32'h11, "acc_add");
        do_op(1'b0, 1'b1, 32'hFFFFFFFF, 32'd1, 34, 32'd0, 32'h10, "acc_signed");
        acc = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
